// File: rtl/multicycle_control_fsm.sv
// Instruction sequencer for the multicycle datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with req/ack memory handshakes, a per-request timeout, and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int OPC_WIDTH = 3,
  parameter int MAX_WAIT  = 15,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [OPC_WIDTH-1:0] opcode,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 alu_en,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic                 halted,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  // +2 keeps the width non-zero and able to hold MAX_WAIT itself.
  localparam int WAIT_W = $clog2(MAX_WAIT + 2);
  localparam logic [OPC_WIDTH-1:0] OPC_LOAD  = '0;
  localparam logic [OPC_WIDTH-1:0] OPC_STORE = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_HALT  = '1;
  localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(MAX_WAIT);

  state_t                 state_q;
  logic [OPC_WIDTH-1:0]   opc_q;
  logic [WAIT_W-1:0]      wait_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_MAX) begin
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          opc_q <= opcode;
          if (opcode == OPC_HALT) begin
            state_q <= S_HALT;
          end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
            state_q <= S_MEMORY;
            wait_q  <= '0;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: state_q <= S_WRITEBACK;
        S_MEMORY: begin
          if (dmem_ack) begin
            if (opc_q == OPC_LOAD) begin
              state_q <= S_WRITEBACK;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= run ? S_FETCH : S_IDLE;
              wait_q  <= '0;
            end
          end else if (wait_q == WAIT_MAX) begin
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WRITEBACK: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= run ? S_FETCH : S_IDLE;
          wait_q  <= '0;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign ir_load     = imem_req & imem_ack;
  assign pc_inc      = imem_req & imem_ack;
  assign dmem_req    = (state_q == S_MEMORY);
  assign dmem_we     = dmem_req & (opc_q == OPC_STORE);
  assign alu_en      = (state_q == S_EXECUTE);
  assign reg_we      = (state_q == S_WRITEBACK);
  // Source select only matters while writing; held low otherwise so reset leaves it 0.
  assign wb_sel      = reg_we & (opc_q == OPC_LOAD);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-by-cycle vector bench for multicycle_control_fsm with an expected-value queue.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, dmem_ack;
  logic [2:0]  opcode;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_inc, alu_en, reg_we, wb_sel, halted, fault;
  logic [2:0]  state;
  logic [31:0] instr_count;

  multicycle_control_fsm #(.OPC_WIDTH(3), .MAX_WAIT(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc), .alu_en(alu_en), .reg_we(reg_we),
    .wb_sel(wb_sel), .halted(halted), .fault(fault),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // outs order: imem_req dmem_req dmem_we ir_load pc_inc alu_en reg_we wb_sel halted fault
  typedef struct {
    logic        rst, run, iack, dack;
    logic [2:0]  op;
    logic [2:0]  st;
    logic [9:0]  outs;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [9:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_FACK  = 10'b1001100000;
  localparam logic [9:0] O_FWAIT = 10'b1000000000;
  localparam logic [9:0] O_LDMEM = 10'b0100000000;
  localparam logic [9:0] O_STMEM = 10'b0110000000;
  localparam logic [9:0] O_ALU   = 10'b0000010000;
  localparam logic [9:0] O_WBALU = 10'b0000001000;
  localparam logic [9:0] O_WBLD  = 10'b0000001100;
  localparam logic [9:0] O_HALT  = 10'b0000000010;
  localparam logic [9:0] O_FAULT = 10'b0000000001;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic rn, input logic [2:0] op, input logic ia,
                     input logic da, input logic [2:0] st, input logic [9:0] o,
                     input logic [31:0] c);
    vec_t v;
    v.rst = r; v.run = rn; v.op = op; v.iack = ia; v.dack = da;
    v.st = st; v.outs = o; v.cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; run = 1'b0; opcode = 3'd0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then ADD with zero-wait fetch
    add(1, 0, 0, 0, 0, 0, O_NONE,  0);
    add(0, 1, 0, 1, 0, 0, O_NONE,  0);
    add(0, 1, 2, 1, 0, 1, O_FACK,  0);
    add(0, 1, 2, 1, 0, 2, O_NONE,  0);
    add(0, 1, 2, 1, 0, 3, O_ALU,   0);
    add(0, 1, 2, 1, 0, 5, O_WBALU, 0);
    // STORE, immediate dmem_ack, retires straight from MEMORY
    add(0, 1, 1, 1, 0, 1, O_FACK,  1);
    add(0, 1, 1, 1, 0, 2, O_NONE,  1);
    add(0, 1, 1, 1, 1, 4, O_STMEM, 1);
    // LOAD, dmem_ack three cycles after entering MEMORY
    add(0, 1, 0, 1, 0, 1, O_FACK,  2);
    add(0, 1, 0, 1, 0, 2, O_NONE,  2);
    add(0, 1, 0, 1, 0, 4, O_LDMEM, 2);
    add(0, 1, 0, 1, 0, 4, O_LDMEM, 2);
    add(0, 1, 0, 1, 0, 4, O_LDMEM, 2);
    add(0, 1, 0, 1, 1, 4, O_LDMEM, 2);
    add(0, 1, 0, 1, 0, 5, O_WBLD,  2);
    // LOAD with stray dmem_ack in FETCH, run dropped during the MEMORY wait
    add(0, 1, 0, 1, 1, 1, O_FACK,  3);
    add(0, 1, 0, 1, 0, 2, O_NONE,  3);
    add(0, 0, 0, 1, 0, 4, O_LDMEM, 3);
    add(0, 0, 0, 0, 1, 4, O_LDMEM, 3);
    add(0, 0, 0, 0, 0, 5, O_WBLD,  3);
    add(0, 0, 0, 1, 0, 0, O_NONE,  4);
    add(0, 0, 0, 1, 0, 0, O_NONE,  4);
    // reset asserted while a STORE waits in MEMORY
    add(0, 1, 1, 1, 0, 0, O_NONE,  4);
    add(0, 1, 1, 1, 0, 1, O_FACK,  4);
    add(0, 1, 1, 1, 0, 2, O_NONE,  4);
    add(1, 1, 1, 0, 0, 4, O_STMEM, 4);
    add(0, 0, 0, 0, 0, 0, O_NONE,  0);
    // two ALU ops then HALT
    add(0, 1, 2, 1, 0, 0, O_NONE,  0);
    add(0, 1, 2, 1, 0, 1, O_FACK,  0);
    add(0, 1, 2, 1, 0, 2, O_NONE,  0);
    add(0, 1, 2, 1, 0, 3, O_ALU,   0);
    add(0, 1, 2, 1, 0, 5, O_WBALU, 0);
    add(0, 1, 6, 1, 0, 1, O_FACK,  1);
    add(0, 1, 6, 1, 0, 2, O_NONE,  1);
    add(0, 1, 6, 1, 0, 3, O_ALU,   1);
    add(0, 1, 6, 1, 0, 5, O_WBALU, 1);
    add(0, 1, 7, 1, 0, 1, O_FACK,  2);
    add(0, 1, 7, 1, 0, 2, O_NONE,  2);
    add(0, 1, 7, 1, 1, 6, O_HALT,  2);
    add(0, 1, 7, 1, 1, 6, O_HALT,  2);
    add(1, 1, 0, 1, 0, 6, O_HALT,  2);
    // fetch timeout: 16 unacked cycles then FAULT, held until reset
    add(0, 1, 0, 0, 0, 0, O_NONE,  0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 0, 1, O_FWAIT, 0);
    add(0, 1, 0, 1, 1, 7, O_FAULT, 0);
    add(0, 1, 0, 1, 1, 7, O_FAULT, 0);
    add(1, 0, 0, 0, 0, 7, O_FAULT, 0);
    add(0, 0, 0, 0, 0, 0, O_NONE,  0);
    // ack on the last permitted cycle is still accepted
    add(0, 1, 2, 0, 0, 0, O_NONE,  0);
    for (int i = 0; i < 15; i++) add(0, 1, 2, 0, 0, 1, O_FWAIT, 0);
    add(0, 1, 2, 1, 0, 1, O_FACK,  0);
    add(0, 0, 2, 0, 0, 2, O_NONE,  0);
    add(0, 0, 2, 0, 0, 3, O_ALU,   0);
    add(0, 0, 2, 0, 0, 5, O_WBALU, 0);
    add(0, 0, 2, 0, 0, 0, O_NONE,  1);
    // data-memory timeout on a LOAD, with stray imem_ack ignored
    add(0, 1, 0, 1, 0, 0, O_NONE,  1);
    add(0, 1, 0, 1, 0, 1, O_FACK,  1);
    add(0, 1, 0, 1, 0, 2, O_NONE,  1);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 1, 0, 4, O_LDMEM, 1);
    add(0, 1, 0, 0, 1, 7, O_FAULT, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; run = vecs[i].run; opcode = vecs[i].op;
      imem_ack = vecs[i].iack; dmem_ack = vecs[i].dack;
      e.idx = i; e.st = vecs[i].st; e.outs = vecs[i].outs; e.cnt = vecs[i].cnt;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks += 3;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL vec%0d state: got %0d want %0d", e.idx, state, e.st);
      end
      if ({imem_req, dmem_req, dmem_we, ir_load, pc_inc, alu_en, reg_we, wb_sel, halted, fault} !== e.outs) begin
        n_fail++;
        $display("FAIL vec%0d outs: got %b want %b", e.idx,
                 {imem_req, dmem_req, dmem_we, ir_load, pc_inc, alu_en, reg_we, wb_sel, halted, fault}, e.outs);
      end
      if (instr_count !== e.cnt) begin
        n_fail++;
        $display("FAIL vec%0d instr_count: got %0d want %0d", e.idx, instr_count, e.cnt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
